// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the J1 interrupt controller:
// FSM state names, IO register addresses and status-word field positions.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [15:0] ADDR_STATUS = 16'h0800;
  localparam logic [15:0] ADDR_MASK   = 16'h0880;

  localparam int STAT_INSVC_BIT = 15;
  localparam int STAT_VEC_MSB   = 10;
  localparam int STAT_VEC_LSB   = 8;
  localparam int STAT_PEND_MSB  = 7;

  localparam int VEC_W = 3;

endpackage

// File: rtl/irq_ctrl_if.sv
// J1 IO bus slice seen by the interrupt controller; the CPU side is master.
interface irq_ctrl_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;

  modport master (output io_rd, output io_wr, output io_addr, output io_dout, input io_din);
  modport slave  (input io_rd, input io_wr, input io_addr, input io_dout, output io_din);
endinterface

// File: rtl/irq_ctrl_prio_pick.sv
// Combinational winner pick: the requesting index closest at or after
// start (wrapping modulo N_SRC) wins.
module irq_prio_pick
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  input  logic [VEC_W-1:0] start,
  output logic             valid,
  output logic [VEC_W-1:0] idx
);

  int best_d;
  int d;

  always_comb begin
    valid  = |req;
    idx    = '0;
    best_d = N_SRC;
    d      = 0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i]) begin
        d = (i >= int'(start)) ? (i - int'(start)) : (i + N_SRC - int'(start));
        if (d < best_d) begin
          best_d = d;
          idx    = VEC_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller for the J1 IO bus (status 0x0800, mask 0x0880).
// Build option IRQ_CTRL_ROUNDROBIN_EN selects round-robin instead of fixed priority.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC   = 8,
  parameter int SEL_BIT = 11,
  parameter int SUB_BIT = 7
) (
  input  logic             clk,
  input  logic             reset,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] src,
  output logic             interrupt_request,
  output logic             in_service
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_REQ     = REQ;
  localparam logic [1:0] S_SERVICE = SERVICE;

  logic [N_SRC-1:0] src_q_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] enable_reg;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [VEC_W-1:0] vector_reg;
  logic [VEC_W-1:0] pick_idx;
  logic [VEC_W-1:0] pick_start;
  logic             pick_valid;
  logic             irq_reg;
  logic             in_service_reg;
  logic             sel;
  logic             stat_wr;
  logic             mask_wr;
  logic [7:0]       pend_rd;
  logic [7:0]       en_rd;
  logic [15:0]      status_rd;
  logic             unused_bus;

  assign sel     = bus.io_addr[SEL_BIT];
  assign stat_wr = bus.io_wr & sel & ~bus.io_addr[SUB_BIT];
  assign mask_wr = bus.io_wr & sel &  bus.io_addr[SUB_BIT];

  // Set terms (hardware edge, software trigger) dominate the EOI clear.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_pend
      assign pending_next[gi] = (src[gi] & ~src_q_reg[gi])
                              | (mask_wr & bus.io_dout[8+gi])
                              | (pending_reg[gi] & ~(stat_wr & bus.io_dout[gi]));
    end
  endgenerate

  irq_prio_pick #(.N_SRC(N_SRC)) u_pick (
    .req   (pending_reg & enable_reg),
    .start (pick_start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef IRQ_CTRL_ROUNDROBIN_EN
  logic [VEC_W-1:0] last_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_reg <= VEC_W'(N_SRC - 1);
    end else if (state_reg == S_IDLE && pick_valid) begin
      last_reg <= pick_idx;
    end
  end

  assign pick_start = (last_reg == VEC_W'(N_SRC - 1)) ? '0 : last_reg + VEC_W'(1);
`else
  assign pick_start = '0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (pick_valid) state_next = S_REQ;
      S_REQ:     state_next = S_SERVICE;
      S_SERVICE: if (stat_wr) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q_reg      <= '0;
      pending_reg    <= '0;
      enable_reg     <= '0;
      state_reg      <= S_IDLE;
      vector_reg     <= '0;
      irq_reg        <= 1'b0;
      in_service_reg <= 1'b0;
    end else begin
      src_q_reg   <= src;
      pending_reg <= pending_next;
      state_reg   <= state_next;
      irq_reg     <= (state_reg == S_REQ);
      if (mask_wr) enable_reg <= bus.io_dout[N_SRC-1:0];
      if (state_reg == S_IDLE && pick_valid) vector_reg <= pick_idx;
      if (state_reg == S_REQ) begin
        in_service_reg <= 1'b1;
      end else if (state_reg == S_SERVICE && stat_wr) begin
        in_service_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    pend_rd                = '0;
    pend_rd[N_SRC-1:0]     = pending_reg;
    en_rd                  = '0;
    en_rd[N_SRC-1:0]       = enable_reg;
    status_rd              = '0;
    status_rd[STAT_INSVC_BIT]             = in_service_reg;
    status_rd[STAT_VEC_MSB:STAT_VEC_LSB]  = vector_reg;
    status_rd[STAT_PEND_MSB:0]            = pend_rd;
  end

  assign bus.io_din = !sel ? 16'h0000 : (bus.io_addr[SUB_BIT] ? {8'h00, en_rd} : status_rd);

  assign interrupt_request = irq_reg;
  assign in_service        = in_service_reg;

  // Reads have no side effects and only the one-hot select bits are decoded.
  assign unused_bus = &{1'b0, bus.io_rd, bus.io_addr, bus.io_dout};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios plus randomized bus/source traffic, checked every cycle
// against a timeline model of pending/enable/grant behaviour.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] src;
  logic         irq;
  logic         insvc;

  irq_ctrl_if bus();

  irq_ctrl #(.N_SRC(N), .SEL_BIT(11), .SUB_BIT(7)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .src               (src),
    .interrupt_request (irq),
    .in_service        (insvc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: registers as bit masks, a grant recorded as the edge it happened on.
  int         edge_n;
  logic [7:0] m_pend, m_en, m_srcq;
  logic [2:0] m_vec;
  logic       m_busy;
  int         m_grant;
  int         m_last;

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_srcq = '0; m_vec = '0;
    m_busy = 1'b0; m_grant = -10; m_last = N - 1;
  endtask

  function automatic int pick(input logic [7:0] req);
`ifdef IRQ_CTRL_ROUNDROBIN_EN
    for (int o = 1; o <= N; o++) begin
      int c;
      c = (m_last + o) % N;
      if (req[c[2:0]]) return c;
    end
`else
    for (int i = 0; i < N; i++) if (req[i[2:0]]) return i;
`endif
    return 0;
  endfunction

  function automatic logic m_insvc();
    return m_busy && (edge_n >= m_grant + 1);
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (!a[11]) return 16'h0000;
    if (a[7])   return {8'h00, m_en};
    return {m_insvc(), 4'b0000, m_vec, m_pend};
  endfunction

  task automatic step_model();
    logic       sw, mw;
    logic [7:0] req, set_b, clr_b;
    int         w;
    edge_n++;
    sw  = bus.io_wr && (bus.io_addr == ADDR_STATUS);
    mw  = bus.io_wr && (bus.io_addr == ADDR_MASK);
    req = m_pend & m_en;
    if (!m_busy && req != 8'h00) begin
      w = pick(req);
      m_vec = w[2:0]; m_last = w; m_busy = 1'b1; m_grant = edge_n;
    end else if (m_busy && sw && edge_n > m_grant + 1) begin
      m_busy = 1'b0;
    end
    set_b  = (src & ~m_srcq) | (mw ? bus.io_dout[15:8] : 8'h00);
    clr_b  = sw ? bus.io_dout[7:0] : 8'h00;
    m_pend = set_b | (m_pend & ~clr_b);
    if (mw) m_en = bus.io_dout[7:0];
    m_srcq = src;
  endtask

  task automatic tick();
    @(posedge clk);
    step_model();
    #1;
    check_eq("irq", 32'(irq), 32'(edge_n == m_grant + 1));
    check_eq("in_service", 32'(insvc), 32'(m_insvc()));
  endtask

  task automatic drive(input logic wr, input logic [15:0] addr, input logic [15:0] dout,
                       input logic [7:0] s);
    bus.io_wr   = wr;
    bus.io_rd   = !wr && addr[11];
    bus.io_addr = addr;
    bus.io_dout = dout;
    src         = s;
    #1;
    check_eq("io_din", 32'(bus.io_din), 32'(m_read(addr)));
    if (wr) $display("edge %0d: write %h <= %h src=%h", edge_n, addr, dout, s);
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [15:0] dout, input logic [7:0] s);
    drive(1'b1, addr, dout, s);
    tick();
  endtask

  task automatic idle(input logic [7:0] s, input int n);
    repeat (n) begin
      drive(1'b0, ADDR_STATUS, 16'h0000, s);
      tick();
    end
  endtask

  logic [15:0] raddr;
  logic [7:0]  srcv;
  int          t;

  initial begin
    reset = 1'b1; src = '0;
    bus.io_wr = 1'b0; bus.io_rd = 1'b0; bus.io_addr = ADDR_STATUS; bus.io_dout = '0;
    edge_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_insvc", 32'(insvc), 32'd0);
    check_eq("rst_status", 32'(bus.io_din), 32'h0000);

    // single source, exact request latency
    wr_reg(ADDR_MASK, 16'h0001, 8'h00);
    drive(1'b0, ADDR_STATUS, 16'h0, 8'h01); tick();
    drive(1'b0, ADDR_STATUS, 16'h0, 8'h00);
    check_eq("t1_pend", 32'(bus.io_din), 32'h0001);
    tick(); tick();
    check_eq("t1_irq_hi", 32'(irq), 32'd1);
    drive(1'b0, ADDR_STATUS, 16'h0, 8'h00);
    check_eq("t1_status", 32'(bus.io_din), 32'h8001);
    tick();
    check_eq("t1_irq_lo", 32'(irq), 32'd0);
    wr_reg(ADDR_STATUS, 16'h0001, 8'h00);
    idle(8'h00, 3);
    check_eq("t1_idle", 32'(bus.io_din), 32'h0000);

    // two sources, fixed priority then EOI hand-over
    wr_reg(ADDR_MASK, 16'h000C, 8'h00);
    drive(1'b0, ADDR_STATUS, 16'h0, 8'h0C); tick();
    idle(8'h00, 3);
    check_eq("t2_vec2", 32'(bus.io_din), 32'h820C);
    wr_reg(ADDR_STATUS, 16'h0004, 8'h00);
    idle(8'h00, 3);
    check_eq("t2_vec3", 32'(bus.io_din), 32'h8308);
    wr_reg(ADDR_STATUS, 16'h0008, 8'h00);
    idle(8'h00, 4);
    check_eq("t2_done", 32'(bus.io_din), 32'h0300);

    // masked source waits, then requests two edges after the enable
    wr_reg(ADDR_MASK, 16'h0000, 8'h00);
    drive(1'b0, ADDR_STATUS, 16'h0, 8'h20); tick();
    idle(8'h00, 3);
    check_eq("t3_masked", 32'(bus.io_din), 32'h0320);
    wr_reg(ADDR_MASK, 16'h0020, 8'h00);
    idle(8'h00, 2);
    check_eq("t3_irq", 32'(irq), 32'd1);
    idle(8'h00, 1);
    check_eq("t3_status", 32'(bus.io_din), 32'h8520);
    wr_reg(ADDR_STATUS, 16'h0020, 8'h00);
    idle(8'h00, 3);

    // edge coinciding with W1C of the same bit survives
    wr_reg(ADDR_MASK, 16'h0002, 8'h00);
    drive(1'b0, ADDR_STATUS, 16'h0, 8'h02); tick();
    idle(8'h00, 3);
    check_eq("t4_svc", 32'(bus.io_din), 32'h8102);
    drive(1'b1, ADDR_STATUS, 16'h0002, 8'h02); tick();
    drive(1'b0, ADDR_STATUS, 16'h0, 8'h00);
    check_eq("t4_kept", 32'(bus.io_din), 32'h0102);
    tick(); tick();
    check_eq("t4_rereq", 32'(irq), 32'd1);
    idle(8'h00, 1);
    wr_reg(ADDR_STATUS, 16'h0002, 8'h00);
    idle(8'h00, 3);

    // asynchronous reset while the request pulse is high
    wr_reg(ADDR_MASK, 16'h0001, 8'h00);
    drive(1'b0, ADDR_STATUS, 16'h0, 8'h01); tick();
    idle(8'h01, 2);
    check_eq("t5_pre", 32'(irq), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_irq", 32'(irq), 32'd0);
    check_eq("t5_insvc", 32'(insvc), 32'd0);
    check_eq("t5_status", 32'(bus.io_din), 32'h0000);
    bus.io_addr = ADDR_MASK;
    #1;
    check_eq("t5_enable", 32'(bus.io_din), 32'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    bus.io_addr = ADDR_STATUS;
    tick();
    drive(1'b0, ADDR_STATUS, 16'h0, 8'h01);
    check_eq("t5_held_src", 32'(bus.io_din), 32'h0001);
    idle(8'h01, 3);
    wr_reg(ADDR_STATUS, 16'h00FF, 8'h00);
    idle(8'h00, 2);

    // two permanently pending sources: arbitration order across EOIs
    wr_reg(ADDR_MASK, 16'h0303, 8'h00);
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!insvc && t < 20) begin
        idle(8'h00, 1);
        t++;
      end
      check_eq("rr_wait", 32'(insvc), 32'd1);
`ifdef IRQ_CTRL_ROUNDROBIN_EN
      check_eq("rr_vec", 32'(bus.io_din[10:8]), 32'(i % 2));
`else
      check_eq("rr_vec", 32'(bus.io_din[10:8]), 32'd0);
`endif
      wr_reg(ADDR_STATUS, 16'h0000, 8'h00);
    end
    wr_reg(ADDR_STATUS, 16'h00FF, 8'h00);
    wr_reg(ADDR_MASK, 16'h0000, 8'h00);
    idle(8'h00, 4);

    // randomized traffic against the model
    srcv = 8'h00;
    repeat (3000) begin
      t    = int'($urandom_range(0, 99));
      srcv = srcv ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if (t < 6) begin
        drive(1'b1, ADDR_STATUS, 16'($urandom), srcv);
      end else if (t < 10) begin
        drive(1'b1, ADDR_MASK, 16'($urandom), srcv);
      end else begin
        case ($urandom_range(0, 3))
          0:       raddr = ADDR_STATUS;
          1:       raddr = ADDR_MASK;
          2:       raddr = 16'h1000;
          default: raddr = 16'h4000;
        endcase
        drive(1'b0, raddr, 16'($urandom), srcv);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Multi-source interrupt controller between the on-chip peripherals and the J1 single `interrupt_request` input.
- Inputs are the ticks overflow, UART rx valid, UART tx idle, port pin changes and similar sources.
- Each source is edge-detected into a pending register and masked by an enable register.
- One winner is arbitrated and the CPU receives a one-cycle request. Service then holds until software writes end-of-interrupt (EOI).
- Sits on the J1 IO bus beside the ticks and UART decoders. Its `io_din` contribution is ORed into the top-level read mux.

Parameters:
- N_SRC, 8: number of interrupt sources, 1..8.
- SEL_BIT, 11: one-hot `io_addr` bit that selects this block (0x0800).
- SUB_BIT, 7: `io_addr` bit that selects the mask register (0x0880) instead of the status register (0x0800).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- io_rd  in  1  J1 IO read strobe.
- io_wr  in  1  J1 IO write strobe.
- io_addr  in  16  J1 IO address, one-hot decoded.
- io_dout  in  16  J1 write data.
- io_din  out  16  read data; 0 when `io_addr[SEL_BIT]` is 0.
- src  in  N_SRC  interrupt sources, synchronous to clk, active-high level.
- interrupt_request  out  1  registered one-cycle pulse to the J1.
- in_service  out  1  high from request until EOI.

Behaviour:
- Reset values: pending=0, enable=0, src_q=0, vector=0, state=IDLE, interrupt_request=0, in_service=0.
- Because src_q resets to 0, a source already high when reset releases produces one edge.
- Edge detect: at each clk edge, every bit with src & ~src_q sets the matching pending bit.
- Status register 0x0800, read: {in_service, 4'b0, vector[2:0], pending[7:0]}. Pending bits at or above N_SRC read 0.
- Status register 0x0800, write (EOI): pending &= ~io_dout[7:0], i.e. write-1-to-clear. If state=SERVICE, go to IDLE.
- Mask register 0x0880, read: {8'b0, enable[7:0]}.
- Mask register 0x0880, write: enable <= io_dout[7:0]. Additionally, io_dout[15:8] is write-1-to-set on pending (software trigger).
- `io_rd` has no side effects; reads are purely combinational from registers.
- Simultaneous hardware edge and W1C on the same bit: set wins, so the edge is not lost.
- Simultaneous W1S and W1C cannot occur, because the two registers have different addresses.
- FSM IDLE: if |(pending & enable), latch the winning index into vector and go to REQ. Otherwise stay in IDLE.
- FSM REQ: drive interrupt_request=1 for exactly one cycle, set in_service=1, go to SERVICE.
- FSM SERVICE: no new request is issued. Wait for an EOI write, then in_service=0 and go to IDLE.
- The winner is not cleared automatically; software must W1C its bit in the EOI write.
- Latency: a source rising when sampled at edge k sets pending at edge k. The FSM enters REQ at edge k+1. interrupt_request is high between edges k+2 and k+3.
- Back-to-back: after EOI, a still-pending enabled source re-requests, with interrupt_request high 2 edges after the EOI edge.
- Disabling a source while in SERVICE has no effect until EOI. A disabled pending bit stays pending and is requested once it is enabled.
- Priority: fixed, with the lowest index winning.
- Asynchronous reset mid-SERVICE: everything returns to reset values immediately and interrupt_request drops combinationally from the flop reset.

Optional Feature:
- Macro: IRQ_CTRL_ROUNDROBIN_EN.
- Defined: round-robin arbitration. The search starts at (last granted vector + 1) mod N_SRC. The last-granted pointer resets to N_SRC-1, so index 0 wins the first grant.
- Undefined: fixed lowest-index priority, and the pointer register is not built.

Decomposition:
- Package irq_ctrl_pkg holds:
  - the FSM state enum {IDLE, REQ, SERVICE};
  - the register address constants 0x0800 and 0x0880;
  - the status field bit positions: in_service=15, vector=10:8, pending=7:0.
- Sub-module irq_prio_pick: combinational pick of the winner index from (pending & enable), given a start pointer. The start pointer is tied to 0 when round-robin is not compiled in.

Test Plan:
- Enable=0x01; pulse src[0] at edge k -> pending=0x01 at k; interrupt_request high exactly one cycle between edges k+2 and k+3; status reads 0x8001 (in_service=1, vector=0).
- Pending=0x0C with enable=0x0C, fixed priority -> vector=2. EOI write 0x0004 -> second request has vector=3. EOI write 0x0008 -> pending=0, no further request.
- src[5] edge with enable=0 -> pending bit 5 set, no request. Write 0x0880=0x0020 -> request follows 2 edges later, vector=5.
- src[1] edge in the same cycle as an EOI W1C of bit 1 -> pending bit 1 remains 1 and re-requests after EOI.
- Assert reset during SERVICE -> io_din=0, interrupt_request=0, in_service=0, enable=0. A held-high src[0] after release sets pending=0x01.
- IRQ_CTRL_ROUNDROBIN_EN defined, enable=0x03, src[0] and src[1] kept pending -> vectors alternate 0,1,0,1. Without the macro -> always vector 0.
